// File: rtl/pc_gen.sv
// pc_gen: RV32 fetch PC generator with trap/redirect priority, a one-entry pending redirect and alignment checking.
// Defining PC_RVC_EN adds the is_c port for 2-byte steps and switches to halfword alignment.
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
`ifdef PC_RVC_EN
  input  logic            is_c,
`endif
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign,
  output logic            pend_valid
);
  typedef enum logic {BOOT, RUN} state_t;
`ifdef PC_RVC_EN
  localparam logic [XLEN-1:0] AMASK = XLEN'(1);
`else
  localparam logic [XLEN-1:0] AMASK = XLEN'(3);
`endif
  state_t state;
  logic pend_trap;
  logic [XLEN-1:0] pend_target, step, nxt;
  logic nxt_mis;
  always_comb begin
`ifdef PC_RVC_EN
    step = is_c ? XLEN'(2) : XLEN'(INC);
`else
    step = XLEN'(INC);
`endif
    nxt = trap_valid ? trap_target & ~AMASK
        : redir_valid ? redir_target & ~AMASK
        : pend_valid ? pend_target & ~AMASK
        : pc_out + step;
    nxt_mis = !trap_valid && (redir_valid ? |(redir_target & AMASK)
                                          : pend_valid && !pend_trap && |(pend_target & AMASK));
  end
  // Pending kind is (pend_valid, pend_trap); a pending trap locks out later redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc_out      <= RESET_VECTOR;
      pc_valid    <= 1'b0;
      misalign    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_trap   <= 1'b0;
      pend_target <= '0;
    end else if (state == BOOT) begin
      state    <= RUN;
      pc_valid <= 1'b1;
    end else if (en) begin
      pc_out     <= nxt;
      misalign   <= nxt_mis;
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (trap_valid) begin
        pend_target <= trap_target;
        pend_trap   <= 1'b1;
        pend_valid  <= 1'b1;
      end else if (redir_valid && !(pend_valid && pend_trap)) begin
        pend_target <= redir_target;
        pend_trap   <= 1'b0;
        pend_valid  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus for pc_gen with a behavioural next-PC model checked every cycle.
module tb_pc_gen;
  logic clk = 0, rst = 0, en = 0, redir_valid = 0, trap_valid = 0;
  logic [31:0] redir_target = 0, trap_target = 0;
  logic [31:0] pc_out;
  logic pc_valid, misalign, pend_valid;
  int checks = 0, errors = 0;
`ifdef PC_RVC_EN
  logic is_c = 0;
  localparam logic [31:0] AM = 32'h1;
`else
  localparam logic [31:0] AM = 32'h3;
`endif

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INC(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
`ifdef PC_RVC_EN
    .is_c(is_c),
`endif
    .pc_out(pc_out), .pc_valid(pc_valid), .misalign(misalign), .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  logic [31:0] m_pc, m_pt;
  logic m_run, m_mis, m_pv, m_ptrap;

  function automatic logic [31:0] m_step();
`ifdef PC_RVC_EN
    return is_c ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_run = 0; m_mis = 0; m_pv = 0; m_ptrap = 0; m_pt = 0;
    end else if (!m_run) m_run = 1;
    else if (en) begin
      if (trap_valid) begin m_pc = trap_target & ~AM; m_mis = 0; end
      else if (redir_valid) begin m_pc = redir_target & ~AM; m_mis = (redir_target & AM) != 0; end
      else if (m_pv) begin m_pc = m_pt & ~AM; m_mis = !m_ptrap && (m_pt & AM) != 0; end
      else begin m_pc = m_pc + m_step(); m_mis = 0; end
      m_pv = 0;
    end else begin
      m_mis = 0;
      if (trap_valid) begin m_pt = trap_target; m_ptrap = 1; m_pv = 1; end
      else if (redir_valid && !(m_pv && m_ptrap)) begin m_pt = redir_target; m_ptrap = 0; m_pv = 1; end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model pc", pc_out, m_pc);
    chk("model pc_valid", {31'b0, pc_valid}, {31'b0, m_run});
    chk("model misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("model pend_valid", {31'b0, pend_valid}, {31'b0, m_pv});
  end

  task automatic cyc(input logic e, input logic rv, input logic [31:0] rt,
                     input logic tv, input logic [31:0] tt);
    en = e; redir_valid = rv; redir_target = rt; trap_valid = tv; trap_target = tt;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1;
    en = 1;
    @(negedge clk);
    chk("reset pc", pc_out, 32'h0);
    chk("reset valid", {31'b0, pc_valid}, 32'h0);
    rst = 0;
    cyc(1, 0, 0, 0, 0); chk("boot pc", pc_out, 32'h0); chk("boot valid", {31'b0, pc_valid}, 32'h1);
    cyc(1, 0, 0, 0, 0); chk("seq 4", pc_out, 32'h4);
    cyc(1, 0, 0, 0, 0); chk("seq 8", pc_out, 32'h8);
    cyc(1, 0, 0, 0, 0); chk("seq c", pc_out, 32'hC);
    cyc(1, 0, 0, 0, 0); chk("seq 10", pc_out, 32'h10);
    cyc(0, 1, 32'h200, 0, 0); chk("stall hold", pc_out, 32'h10); chk("stall pend", {31'b0, pend_valid}, 32'h1);
    cyc(0, 0, 0, 0, 0); chk("stall hold2", pc_out, 32'h10);
    cyc(1, 0, 0, 0, 0); chk("pend used", pc_out, 32'h200); chk("pend cleared", {31'b0, pend_valid}, 32'h0);
    cyc(1, 0, 0, 0, 0); chk("after pend", pc_out, 32'h204);
    cyc(1, 1, 32'h300, 1, 32'h8000_0000); chk("trap beats redir", pc_out, 32'h8000_0000);
    cyc(1, 0, 0, 0, 0); chk("after trap", pc_out, 32'h8000_0004);
    cyc(0, 0, 0, 1, 32'h8000_0000);
    cyc(0, 1, 32'h400, 0, 0); chk("trap pend kept", {31'b0, pend_valid}, 32'h1);
    cyc(1, 0, 0, 0, 0); chk("pend trap wins", pc_out, 32'h8000_0000);
    cyc(0, 1, 32'h500, 0, 0);
    cyc(0, 1, 32'h600, 0, 0);
    cyc(1, 0, 0, 0, 0); chk("newer redir", pc_out, 32'h600);
    cyc(0, 1, 32'h700, 0, 0);
    cyc(0, 0, 0, 1, 32'h900);
    cyc(1, 0, 0, 0, 0); chk("trap replaces redir", pc_out, 32'h900);
    cyc(0, 1, 32'hB00, 1, 32'hA00);
    cyc(1, 0, 0, 0, 0); chk("stall simul trap", pc_out, 32'hA00);
    cyc(1, 1, 32'h102, 0, 0);
`ifndef PC_RVC_EN
    chk("mis redir pc", pc_out, 32'h100); chk("mis redir flag", {31'b0, misalign}, 32'h1);
`endif
    cyc(1, 0, 0, 0, 0); chk("mis one cycle", {31'b0, misalign}, 32'h0);
    cyc(1, 0, 0, 1, 32'h203);
`ifndef PC_RVC_EN
    chk("trap align pc", pc_out, 32'h200);
`endif
    chk("trap no mis", {31'b0, misalign}, 32'h0);
    cyc(0, 1, 32'h301, 0, 0); chk("stall no mis", {31'b0, misalign}, 32'h0);
    cyc(1, 0, 0, 0, 0); chk("pend mis pc", pc_out, 32'h300); chk("pend mis flag", {31'b0, misalign}, 32'h1);
    cyc(0, 1, 32'h800, 0, 0);
    cyc(1, 1, 32'h850, 0, 0); chk("direct over pend", pc_out, 32'h850); chk("override clears", {31'b0, pend_valid}, 32'h0);
    cyc(1, 1, 32'hFFFF_FFFC, 0, 0); chk("pre wrap", pc_out, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0); chk("wrap", pc_out, 32'h0); chk("wrap no mis", {31'b0, misalign}, 32'h0);
    cyc(1, 0, 0, 0, 0); chk("post wrap", pc_out, 32'h4);
    cyc(0, 1, 32'h1000, 0, 0); chk("pre rst pend", {31'b0, pend_valid}, 32'h1);
    #2 rst = 1;
    #1;
    chk("async rst pc", pc_out, 32'h0);
    chk("async rst pend", {31'b0, pend_valid}, 32'h0);
    chk("async rst valid", {31'b0, pc_valid}, 32'h0);
    en = 0; redir_valid = 0;
    @(negedge clk);
    rst = 0;
    cyc(1, 0, 0, 0, 0); chk("reboot pc", pc_out, 32'h0); chk("reboot valid", {31'b0, pc_valid}, 32'h1);
    cyc(1, 0, 0, 0, 0); chk("reboot seq", pc_out, 32'h4); chk("reboot no pend", {31'b0, pend_valid}, 32'h0);
`ifdef PC_RVC_EN
    cyc(1, 1, 32'h10, 0, 0);
    is_c = 1;
    cyc(1, 0, 0, 0, 0); chk("rvc step", pc_out, 32'h12);
    is_c = 0;
    cyc(1, 1, 32'h13, 0, 0); chk("rvc mis pc", pc_out, 32'h12); chk("rvc mis flag", {31'b0, misalign}, 32'h1);
    cyc(1, 1, 32'h102, 0, 0); chk("rvc half ok", pc_out, 32'h102); chk("rvc half no mis", {31'b0, misalign}, 32'h0);
`endif
    cyc(1, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RV32 pipeline fetch stage.
- Replaces the plain enable-gated PC register with the following features:
  - configurable width and reset vector
  - trap and branch redirect with fixed priority
  - a one-entry pending-redirect buffer, so redirects that arrive during a stall are not lost
  - target alignment checking
- Sits between the EX/trap logic and the instruction-memory address port.

Parameters:
- XLEN, 32, width of the PC and of all target ports.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- INC, 4, sequential increment in bytes for a 32-bit instruction.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 = fetch stall, so the PC holds.
- redir_valid  in  1  branch/jump redirect request from EX.
- redir_target  in  XLEN  redirect target address.
- trap_valid  in  1  trap/exception redirect request.
- trap_target  in  XLEN  trap handler address (mtvec-derived).
- pc_out  out  XLEN  current fetch address (registered).
- pc_valid  out  1  high once the FSM is in RUN.
- misalign  out  1  registered flag: a misaligned redirect target was loaded this cycle.
- pend_valid  out  1  a redirect is held in the pending buffer.

Behaviour:
- Reset (async, rst=1): pc_out=RESET_VECTOR, pc_valid=0, misalign=0, pend_valid=0, pending kind=none, state=BOOT. Reset asserted mid-operation discards any pending redirect immediately.
- FSM states: BOOT and RUN.
  - BOOT: on the first rising edge with rst=0, go to RUN and set pc_valid=1. pc_out stays RESET_VECTOR. All inputs are ignored in BOOT.
  - RUN: pc_valid=1 permanently until the next reset.
- Next-PC selection in RUN, in priority order:
  1. trap_valid
  2. redir_valid
  3. pending entry
  4. pc_out+INC
- en=1:
  - pc_out <= the highest-priority source.
  - A pending entry is consumed (pend_valid<=0) whenever it is used or overridden by a new trap/redirect in the same cycle.
- en=0:
  - pc_out holds.
  - A trap_valid captures trap_target into the pending entry (kind=trap), replacing any pending redirect.
  - A redir_valid without trap_valid captures into the pending entry (kind=redir) only if no trap is pending. A newer redirect replaces an older pending redirect.
  - pend_valid<=1 on capture.
- Simultaneous trap_valid and redir_valid: the trap wins and the redirect is dropped, in both the en=1 and en=0 cases.
- Alignment:
  - Redirect targets (direct or pending) with bits [1:0]!=0 are loaded with bits [1:0] forced to 0, and misalign=1 for exactly the cycle in which that value appears on pc_out. Otherwise misalign=0.
  - Trap targets always have bits [1:0] forced to 0 and never raise misalign.
- Arithmetic: pc_out+INC is computed modulo 2^XLEN. For example, 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Latency: one cycle from a redirect/trap input (with en=1) to the new pc_out.
- No combinational path from any input to any output.

Optional Feature:
- Macro PC_RVC_EN.
- When defined:
  - Adds input port is_c (1 bit). When is_c=1 the sequential increment is 2 instead of INC.
  - Alignment check and forcing apply to bit 0 only (halfword alignment). Trap targets have bit 0 forced to 0.
- When undefined:
  - Port is_c is absent.
  - Increment is always INC and 4-byte alignment rules apply as above.

Test Plan:
- Reset then run: deassert rst with en=1 -> pc_out=0x0 for BOOT and the first RUN cycle (pc_valid 0 then 1), then 0x4, 0x8, 0xC on successive edges.
- Stall plus redirect: at pc=0x10, en=0, pulse redir_valid with target 0x200 -> pc holds 0x10 and pend_valid=1. Raise en -> pc_out=0x200 next edge, pend_valid=0, then 0x204.
- Trap beats redirect: en=1, trap_valid (0x8000_0000) and redir_valid (0x300) in the same cycle -> pc_out=0x8000_0000. Under stall with a pending trap, a later redirect to 0x400 is ignored; on release pc=0x8000_0000.
- Misaligned target: redir_target=0x102 with en=1 -> pc_out=0x100 and misalign=1 for one cycle. trap_target=0x203 -> pc_out=0x200 and misalign=0.
- Wrap and async reset: XLEN=32 at pc=0xFFFF_FFFC with en=1 -> pc_out=0x0. Assert rst between edges with pend_valid=1 -> pc_out=RESET_VECTOR and pend_valid=0 immediately, without waiting for a clock.
- PC_RVC_EN build: is_c=1 at pc=0x10 -> 0x12. redir_target=0x13 -> pc_out=0x12 and misalign=1.
